// File: rtl/filter_out_stage_pkg.sv
// Shared parameters for the filter output stage: filter latency, visible
// frame geometry, count widths and the display-mode encodings.
package filter_out_stage_pkg;

   localparam int SOBEL_DLY = 6;
   localparam int H_ACTIVE  = 1024;
   localparam int V_ACTIVE  = 768;

   localparam int HC_W  = 11;
   localparam int VC_W  = 10;
   localparam int RGB_W = 24;

   typedef enum logic [1:0] {
      MODE_RAW     = 2'd0,
      MODE_SKETCH  = 2'd1,
      MODE_CARTOON = 2'd2,
      MODE_SPLIT   = 2'd3
   } mode_e;

endpackage

// File: rtl/filter_out_stage_delay_pipe.sv
// Fixed-depth shift register with synchronous reset to a per-instance value.
// The output is the last stage, so data emerges DEPTH edges after entry.
module delay_pipe #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] q_reg;
         if (gi == 0) begin : g_head
            // First stage captures the incoming word
            always_ff @(posedge clk) begin
               if (rst) q_reg <= RST_VAL;
               else     q_reg <= din;
            end
         end else begin : g_body
            // Later stages shift the previous stage along by one cycle
            always_ff @(posedge clk) begin
               if (rst) q_reg <= RST_VAL;
               else     q_reg <= g_stage[gi-1].q_reg;
            end
         end
      end
   endgenerate

   assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/filter_out_stage.sv
// Output stage behind the sketch/cartoon filter: realigns the raw pixel and
// VGA timing with the filter latency, latches the display mode at frame
// start, forces raw pixels on the invalid 3x3 border, and registers all
// outputs for the VGA driver.
module filter_out_stage #(
   parameter int PIPE_DLY = filter_out_stage_pkg::SOBEL_DLY,
   parameter int H_ACTIVE = filter_out_stage_pkg::H_ACTIVE,
   parameter int V_ACTIVE = filter_out_stage_pkg::V_ACTIVE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        blank,
   input  logic [23:0] rgb_in,
   input  logic [23:0] rgb_edge,
   input  logic [23:0] rgb_cartoon,
   input  logic [1:0]  mode_sel,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        blank_out,
   output logic [23:0] rgb_out,
   output logic [1:0]  mode_active
);

   import filter_out_stage_pkg::*;

   localparam int TIM_W = HC_W + VC_W + 3;

   localparam logic [HC_W-1:0] H_LAST = HC_W'(H_ACTIVE - 1);
   localparam logic [HC_W-1:0] H_HALF = HC_W'(H_ACTIVE / 2);
   localparam logic [VC_W-1:0] V_LAST = VC_W'(V_ACTIVE - 1);

   // Cleared timing word: counts 0, syncs low, blank high
   localparam logic [TIM_W-1:0] TIM_RST = {{HC_W{1'b0}}, {VC_W{1'b0}}, 1'b0, 1'b0, 1'b1};

   logic [TIM_W-1:0] tim_tap;
   logic [RGB_W-1:0] d_rgb;
   logic [HC_W-1:0]  d_hcount;
   logic [VC_W-1:0]  d_vcount;
   logic             d_hsync;
   logic             d_vsync;
   logic             d_blank;

   delay_pipe #(
      .WIDTH   (TIM_W),
      .DEPTH   (PIPE_DLY),
      .RST_VAL (TIM_RST)
   ) u_tim_dly (
      .clk  (clk),
      .rst  (rst),
      .din  ({hcount, vcount, hsync, vsync, blank}),
      .dout (tim_tap)
   );

   delay_pipe #(
      .WIDTH   (RGB_W),
      .DEPTH   (PIPE_DLY),
      .RST_VAL ('0)
   ) u_rgb_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (rgb_in),
      .dout (d_rgb)
   );

   assign {d_hcount, d_vcount, d_hsync, d_vsync, d_blank} = tim_tap;

   mode_e            mode_active_reg;
   mode_e            mode_next;
   logic             frame_start;
   logic             border;
   logic [RGB_W-1:0] rgb_next;

   logic [HC_W-1:0]  hcount_reg;
   logic [VC_W-1:0]  vcount_reg;
   logic             hsync_reg;
   logic             vsync_reg;
   logic             blank_reg;
   logic [RGB_W-1:0] rgb_reg;

   // Frame-start mode pick-up, border detect and pixel selection in the tap domain.
   // The mux uses mode_next so the pixel leaving on the latch edge already sees the new mode.
   always_comb begin
      frame_start = (d_hcount == '0) && (d_vcount == '0);
      mode_next   = frame_start ? mode_e'(mode_sel) : mode_active_reg;
      border      = (d_hcount == '0) || (d_hcount == H_LAST) ||
                    (d_vcount == '0) || (d_vcount == V_LAST);
      rgb_next    = d_rgb;
      if (d_blank) begin
         rgb_next = '0;
      end else if ((mode_next == MODE_RAW) || border) begin
         rgb_next = d_rgb;
      end else begin
         case (mode_next)
            MODE_SKETCH:  rgb_next = rgb_edge;
            MODE_CARTOON: rgb_next = rgb_cartoon;
            MODE_SPLIT:   rgb_next = (d_hcount < H_HALF) ? d_rgb : rgb_cartoon;
            default:      rgb_next = d_rgb;
         endcase
      end
   end

   // Mode latch: holds between frame starts, reset wins over a coincident frame start
   always_ff @(posedge clk) begin
      if (rst) mode_active_reg <= MODE_RAW;
      else     mode_active_reg <= mode_next;
   end

   // Output register stage for the VGA driver
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_reg <= '0;
         vcount_reg <= '0;
         hsync_reg  <= 1'b0;
         vsync_reg  <= 1'b0;
         blank_reg  <= 1'b1;
         rgb_reg    <= '0;
      end else begin
         hcount_reg <= d_hcount;
         vcount_reg <= d_vcount;
         hsync_reg  <= d_hsync;
         vsync_reg  <= d_vsync;
         blank_reg  <= d_blank;
         rgb_reg    <= rgb_next;
      end
   end

   assign hcount_out  = hcount_reg;
   assign vcount_out  = vcount_reg;
   assign hsync_out   = hsync_reg;
   assign vsync_out   = vsync_reg;
   assign blank_out   = blank_reg;
   assign rgb_out     = rgb_reg;
   assign mode_active = mode_active_reg;

endmodule
